// File: rtl/dbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// dbus_arbiter : round-robin sharing of one data-bus slave port by M0 and M1.
// Revision     : 1.0
// ----------------------------------------------------------------------------

module dbus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic              m0_wr_en,
  output logic              m0_req_ready,
  output logic              m0_rd_valid,
  output logic [DATA_W-1:0] m0_rd_data,

  input  logic              m1_req_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic              m1_wr_en,
  output logic              m1_req_ready,
  output logic              m1_rd_valid,
  output logic [DATA_W-1:0] m1_rd_data,

  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              s_wr_en,
  output logic              s_rd_en,
  input  logic [DATA_W-1:0] s_rd_data
);

  localparam logic c_OWN_M0 = 1'b0;
  localparam logic c_OWN_M1 = 1'b1;

  logic                  last_grant_q, last_grant_d;
  logic                  w_gnt_m0, w_gnt_m1;
  logic                  w_acc_m0, w_acc_m1, w_acc;
  logic                  w_sel_wr;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;

  logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic [DATA_W-1:0]     s_wr_data_q, s_wr_data_d;
  logic                  s_wr_en_q, s_wr_en_d;
  logic                  s_rd_en_q, s_rd_en_d;
  logic                  s_own_q, s_own_d;

  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;
  logic                  w_ret_vld, w_ret_own;

  logic                  m0_rd_valid_q, m0_rd_valid_d;
  logic [DATA_W-1:0]     m0_rd_data_q, m0_rd_data_d;
  logic                  m1_rd_valid_q, m1_rd_valid_d;
  logic [DATA_W-1:0]     m1_rd_data_q, m1_rd_data_d;

  // Under contention the requester that did not win last time is granted.
  always_comb begin
    w_gnt_m0 = m0_req_valid & (~m1_req_valid | (last_grant_q == c_OWN_M1));
    w_gnt_m1 = m1_req_valid & ~w_gnt_m0;
  end

  assign m0_req_ready = w_gnt_m0 & ~reset;
  assign m1_req_ready = w_gnt_m1 & ~reset;

  always_comb begin
    w_acc_m0    = m0_req_valid & m0_req_ready;
    w_acc_m1    = m1_req_valid & m1_req_ready;
    w_acc       = w_acc_m0 | w_acc_m1;
    w_sel_wr    = w_acc_m1 ? m1_wr_en   : m0_wr_en;
    w_sel_addr  = w_acc_m1 ? m1_addr    : m0_addr;
    w_sel_wdata = w_acc_m1 ? m1_wr_data : m0_wr_data;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    s_addr_d     = s_addr_q;
    s_wr_data_d  = s_wr_data_q;
    s_wr_en_d    = 1'b0;
    s_rd_en_d    = 1'b0;
    s_own_d      = s_own_q;
    if (w_acc) begin
      last_grant_d = w_acc_m1 ? c_OWN_M1 : c_OWN_M0;
      s_addr_d     = w_sel_addr;
      s_wr_data_d  = w_sel_wdata;
      s_wr_en_d    = w_sel_wr;
      s_rd_en_d    = ~w_sel_wr;
      s_own_d      = w_acc_m1;
    end
  end

  // Owner tags ride alongside the slave's fixed read latency.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = s_rd_en_q;
    tag_own_d[0] = s_own_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  assign w_ret_vld = tag_vld_q[RD_LATENCY-1];
  assign w_ret_own = tag_own_q[RD_LATENCY-1];

  always_comb begin
    m0_rd_valid_d = w_ret_vld & (w_ret_own == c_OWN_M0);
    m1_rd_valid_d = w_ret_vld & (w_ret_own == c_OWN_M1);
    m0_rd_data_d  = m0_rd_valid_d ? s_rd_data : m0_rd_data_q;
    m1_rd_data_d  = m1_rd_valid_d ? s_rd_data : m1_rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= c_OWN_M1;
      s_addr_q      <= '0;
      s_wr_data_q   <= '0;
      s_wr_en_q     <= 1'b0;
      s_rd_en_q     <= 1'b0;
      s_own_q       <= 1'b0;
      tag_vld_q     <= '0;
      tag_own_q     <= '0;
      m0_rd_valid_q <= 1'b0;
      m0_rd_data_q  <= '0;
      m1_rd_valid_q <= 1'b0;
      m1_rd_data_q  <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      s_addr_q      <= s_addr_d;
      s_wr_data_q   <= s_wr_data_d;
      s_wr_en_q     <= s_wr_en_d;
      s_rd_en_q     <= s_rd_en_d;
      s_own_q       <= s_own_d;
      tag_vld_q     <= tag_vld_d;
      tag_own_q     <= tag_own_d;
      m0_rd_valid_q <= m0_rd_valid_d;
      m0_rd_data_q  <= m0_rd_data_d;
      m1_rd_valid_q <= m1_rd_valid_d;
      m1_rd_data_q  <= m1_rd_data_d;
    end
  end

  assign s_addr      = s_addr_q;
  assign s_wr_data   = s_wr_data_q;
  assign s_wr_en     = s_wr_en_q;
  assign s_rd_en     = s_rd_en_q;
  assign m0_rd_valid = m0_rd_valid_q;
  assign m0_rd_data  = m0_rd_data_q;
  assign m1_rd_valid = m1_rd_valid_q;
  assign m1_rd_data  = m1_rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dbus_arbiter : two arbiters (read latency 1 and 3) against a cycle model.
// Revision        : 1.0
// ----------------------------------------------------------------------------

module tb_dbus_arbiter;

  localparam int N = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        m0_v = 1'b0, m0_w = 1'b0, m1_v = 1'b0, m1_w = 1'b0;
  logic [31:0] m0_a = '0, m0_d = '0, m1_a = '0, m1_d = '0;

  logic [1:0]       rdy0, rdy1, rv0, rv1, swe, sre;
  logic [1:0][31:0] rd0, rd1, saddr, swd, srd;

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_v), .m0_addr(m0_a), .m0_wr_data(m0_d), .m0_wr_en(m0_w),
    .m0_req_ready(rdy0[0]), .m0_rd_valid(rv0[0]), .m0_rd_data(rd0[0]),
    .m1_req_valid(m1_v), .m1_addr(m1_a), .m1_wr_data(m1_d), .m1_wr_en(m1_w),
    .m1_req_ready(rdy1[0]), .m1_rd_valid(rv1[0]), .m1_rd_data(rd1[0]),
    .s_addr(saddr[0]), .s_wr_data(swd[0]), .s_wr_en(swe[0]), .s_rd_en(sre[0]),
    .s_rd_data(srd[0])
  );

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_v), .m0_addr(m0_a), .m0_wr_data(m0_d), .m0_wr_en(m0_w),
    .m0_req_ready(rdy0[1]), .m0_rd_valid(rv0[1]), .m0_rd_data(rd0[1]),
    .m1_req_valid(m1_v), .m1_addr(m1_a), .m1_wr_data(m1_d), .m1_wr_en(m1_w),
    .m1_req_ready(rdy1[1]), .m1_rd_valid(rv1[1]), .m1_rd_data(rd1[1]),
    .s_addr(saddr[1]), .s_wr_data(swd[1]), .s_wr_en(swe[1]), .s_rd_en(sre[1]),
    .s_rd_data(srd[1])
  );

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp_v);
  endtask

  // Slave memory content: a fixed function of the address.
  function automatic logic [31:0] slave_val(input logic [31:0] a);
    return a ^ 32'h0000_1034;
  endfunction

  // Cycle-indexed model schedules: slave issue, read returns, slave data.
  bit          iss_v [N];
  bit          iss_w [N];
  logic [31:0] iss_a [N];
  logic [31:0] iss_d [N];
  bit          ret_v [2][N];
  bit          ret_o [2][N];
  logic [31:0] ret_d [2][N];
  bit          sd_v  [2][N];
  logic [31:0] sd_d  [2][N];
  bit          zero  [N];

  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      srd[k] = (cyc < N && sd_v[k][cyc]) ? sd_d[k][cyc] : $urandom;
  end

  initial begin : p_model
    int          c, win;
    bit          m_last;
    bit          own, e_we, e_re;
    bit          e_rv [2][2];
    logic [31:0] m_saddr, m_swd, a;
    logic [31:0] m_rd [2][2];
    m_last = 1'b1;
    m_saddr = '0;
    m_swd = '0;
    for (int k = 0; k < 2; k++) for (int o = 0; o < 2; o++) m_rd[k][o] = '0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (zero[c]) begin
        m_saddr = '0;
        m_swd = '0;
        for (int k = 0; k < 2; k++) for (int o = 0; o < 2; o++) m_rd[k][o] = '0;
      end
      e_we = 1'b0;
      e_re = 1'b0;
      if (iss_v[c]) begin
        m_saddr = iss_a[c];
        if (iss_w[c]) begin e_we = 1'b1; m_swd = iss_d[c]; end
        else e_re = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        e_rv[k][0] = 1'b0;
        e_rv[k][1] = 1'b0;
        if (ret_v[k][c]) begin
          e_rv[k][ret_o[k][c]] = 1'b1;
          m_rd[k][ret_o[k][c]] = ret_d[k][c];
        end
      end
      if (reset || (!m0_v && !m1_v)) win = -1;
      else if (m0_v && m1_v) win = m_last ? 0 : 1;
      else win = m1_v ? 1 : 0;
      if (c >= 1) begin
        for (int k = 0; k < 2; k++) begin
          chk1($sformatf("inst%0d_m0_ready", k), rdy0[k], win == 0);
          chk1($sformatf("inst%0d_m1_ready", k), rdy1[k], win == 1);
          chk1($sformatf("inst%0d_s_wr_en", k), swe[k], e_we);
          chk1($sformatf("inst%0d_s_rd_en", k), sre[k], e_re);
          chk($sformatf("inst%0d_s_addr", k), saddr[k], m_saddr);
          if (e_we) chk($sformatf("inst%0d_s_wr_data", k), swd[k], m_swd);
          chk1($sformatf("inst%0d_m0_rd_valid", k), rv0[k], e_rv[k][0]);
          chk1($sformatf("inst%0d_m1_rd_valid", k), rv1[k], e_rv[k][1]);
          chk($sformatf("inst%0d_m0_rd_data", k), rd0[k], m_rd[k][0]);
          chk($sformatf("inst%0d_m1_rd_data", k), rd1[k], m_rd[k][1]);
        end
      end
      if (reset) begin
        for (int j = c + 1; j < c + 9; j++) begin
          iss_v[j] = 1'b0;
          ret_v[0][j] = 1'b0;
          ret_v[1][j] = 1'b0;
        end
        zero[c+1] = 1'b1;
        m_last = 1'b1;
      end else if (win >= 0) begin
        own = (win == 1);
        a = own ? m1_a : m0_a;
        iss_v[c+1] = 1'b1;
        iss_w[c+1] = own ? m1_w : m0_w;
        iss_a[c+1] = a;
        iss_d[c+1] = own ? m1_d : m0_d;
        if (!iss_w[c+1]) begin
          for (int k = 0; k < 2; k++) begin
            ret_v[k][c+2+(k*2+1)] = 1'b1;
            ret_o[k][c+2+(k*2+1)] = own;
            ret_d[k][c+2+(k*2+1)] = slave_val(a);
            sd_v[k][c+1+(k*2+1)]  = 1'b1;
            sd_d[k][c+1+(k*2+1)]  = slave_val(a);
          end
        end
        m_last = own;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
    @(negedge clk);
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : p_stim
    int t, acc_j, cnt;
    logic [3:0] vec [8];
    vec = '{4'b1010, 4'b1000, 4'b0010, 4'b1111, 4'b1110, 4'b1011, 4'b0000, 4'b1010};

    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();

    // single write
    t = cyc;
    m0_v = 1'b1; m0_w = 1'b1; m0_a = 32'h100; m0_d = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("wr_m0_ready", rdy0[0], 1'b1);
    tick();
    m0_v = 1'b0;
    @(negedge clk);
    chk1("wr_s_wr_en", swe[0], 1'b1);
    chk("wr_s_addr", saddr[0], 32'h100);
    chk("wr_s_wr_data", swd[0], 32'hDEAD_BEEF);
    go(t + 2);
    chk1("wr_s_wr_en_drop", swe[0], 1'b0);

    // single read
    tick();
    t = cyc;
    m0_v = 1'b1; m0_w = 1'b0; m0_a = 32'h200;
    tick();
    m0_v = 1'b0;
    go(t + 3);
    chk1("rd_l1_m0_valid", rv0[0], 1'b1);
    chk("rd_l1_m0_data", rd0[0], 32'h1234);
    go(t + 5);
    chk1("rd_l3_m0_valid", rv0[1], 1'b1);
    chk("rd_l3_m0_data", rd0[1], 32'h1234);

    // contention from reset release alternates M0, M1, ...
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    m0_v = 1'b1; m0_w = 1'b0; m1_v = 1'b1; m1_w = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m0_a = 32'h300 + 32'(i);
      m1_a = 32'h400 + 32'(i);
      @(negedge clk);
      chk1("rr_m0_ready", rdy0[0], (i % 2) == 0);
      chk1("rr_m1_ready", rdy1[0], (i % 2) == 1);
      if (i > 0)
        chk("rr_s_addr", saddr[0], ((i - 1) % 2 == 0) ? 32'h300 + 32'(i - 1) : 32'h400 + 32'(i - 1));
      tick();
    end
    m0_v = 1'b0; m1_v = 1'b0;

    // three pipelined reads M0, M1, M0 on the latency-3 instance
    tick(); tick();
    t = cyc;
    m0_v = 1'b1; m0_w = 1'b0; m0_a = 32'h103E;
    tick();
    m0_v = 1'b0; m1_v = 1'b1; m1_w = 1'b0; m1_a = 32'h103F;
    tick();
    m1_v = 1'b0; m0_v = 1'b1; m0_a = 32'h1038;
    tick();
    m0_v = 1'b0;
    go(t + 5);
    chk1("pipe_a_valid", rv0[1], 1'b1);
    chk("pipe_a_data", rd0[1], 32'hA);
    go(t + 6);
    chk1("pipe_b_valid", rv1[1], 1'b1);
    chk("pipe_b_data", rd1[1], 32'hB);
    go(t + 7);
    chk1("pipe_c_valid", rv0[1], 1'b1);
    chk("pipe_c_data", rd0[1], 32'hC);

    // M1 streaming writes, M0 cuts in once
    tick();
    acc_j = -1;
    for (int j = 0; j < 8; j++) begin
      m1_v = 1'b1; m1_w = 1'b1; m1_a = 32'h500 + 32'(j); m1_d = 32'h5000 + 32'(j);
      if (j == 3) begin m0_v = 1'b1; m0_w = 1'b1; m0_a = 32'h600; m0_d = 32'h6666; end
      @(negedge clk);
      if (acc_j >= 0 && j == acc_j + 1) chk1("cut_m1_resume", rdy1[0], 1'b1);
      if (m0_v && rdy0[0] && acc_j < 0) acc_j = j;
      tick();
      if (acc_j >= 0) m0_v = 1'b0;
    end
    m0_v = 1'b0; m1_v = 1'b0;
    chk1("cut_m0_latency", (acc_j == 3) || (acc_j == 4), 1'b1);

    // reset while an M1 read is in flight
    tick(); tick(); tick();
    t = cyc;
    m1_v = 1'b1; m1_w = 1'b0; m1_a = 32'h700;
    tick();
    m1_v = 1'b0;
    tick();
    reset = 1'b1;
    m0_v = 1'b1; m0_w = 1'b1; m0_a = 32'h800; m0_d = 32'h8888;
    @(negedge clk);
    chk1("rst_m0_not_ready", rdy0[0], 1'b0);
    tick();
    reset = 1'b0;
    m1_v = 1'b1; m1_w = 1'b1; m1_a = 32'h900; m1_d = 32'h9999;
    @(negedge clk);
    chk1("rst_m0_wins", rdy0[1], 1'b1);
    chk1("rst_m1_loses", rdy1[1], 1'b0);
    chk("rst_s_addr_zero", saddr[1], 32'h0);
    chk("rst_m1_rd_data_zero", rd1[1], 32'h0);
    tick();
    m0_v = 1'b0; m1_v = 1'b0;
    cnt = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      cnt += int'(rv1[1]);
      tick();
    end
    chk("rst_no_stale_return", 32'(cnt), 32'h0);

    // mixed directed vectors {m0_valid, m0_wr, m1_valid, m1_wr}
    for (int i = 0; i < 8; i++) begin
      m0_v = vec[i][3]; m0_w = vec[i][2]; m0_a = 32'hA00 + 32'(i); m0_d = 32'hA0A0_0000 + 32'(i);
      m1_v = vec[i][1]; m1_w = vec[i][0]; m1_a = 32'hB00 + 32'(i); m1_d = 32'hB0B0_0000 + 32'(i);
      tick();
    end
    m0_v = 1'b0; m1_v = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single processor data bus slave port between two requesters.
- M0 is the CPU memory stage; M1 is a secondary master (GPU blitter/DMA).
- Round-robin arbitration, one transaction accepted per cycle, registered slave-side outputs.
- Read data is routed back to the correct requester by an in-order owner-tag pipeline matched to the fixed slave read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from s_rd_en being sampled high to s_rd_data valid; legal range >=1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- m0_req_valid  in  1  M0 request present.
- m0_addr  in  ADDR_W  M0 address.
- m0_wr_data  in  DATA_W  M0 write data.
- m0_wr_en  in  1  1=write, 0=read.
- m0_req_ready  out  1  M0 request accepted this cycle; CPU stalls on ~ready.
- m0_rd_valid  out  1  M0 read data valid.
- m0_rd_data  out  DATA_W  M0 read data.
- m1_req_valid, m1_addr, m1_wr_data, m1_wr_en, m1_req_ready, m1_rd_valid, m1_rd_data: same as M0, for M1.
- s_addr  out  ADDR_W  slave address.
- s_wr_data  out  DATA_W  slave write data.
- s_wr_en  out  1  slave write strobe, one cycle per write.
- s_rd_en  out  1  slave read strobe, one cycle per read.
- s_rd_data  in  DATA_W  slave read data, RD_LATENCY cycles after s_rd_en.

Behaviour:
- Single clock clk; reset synchronous, active-high.
- Reset values: all outputs 0; in-flight tag pipeline cleared; last_grant=M1, so M0 wins the first contention.
- Grant (combinational from current inputs and last_grant):
  - Only one requester valid: that requester is granted.
  - Both valid: the one not equal to last_grant is granted.
  - mX_req_ready = grant to X and ~reset.
  - Accept = valid & ready. last_grant updates to X on accept.
- At most one accept per cycle; no idle bubbles between accepts.
- Slave issue: accept at cycle t gives s_addr/s_wr_data/s_wr_en/s_rd_en registered and driven at t+1 for exactly one cycle.
- s_wr_en and s_rd_en are mutually exclusive; both 0 when there is no accept. s_addr/s_wr_data hold last values when idle.
- Read tags:
  - Shift register, depth RD_LATENCY, entries {valid, owner}.
  - Entry pushed when s_rd_en is driven; pops at t+1+RD_LATENCY.
- Read return:
  - mX_rd_valid and mX_rd_data are registered: asserted for one cycle at t+2+RD_LATENCY for a read accepted at t.
  - Data is s_rd_data captured at t+1+RD_LATENCY.
  - Returns occur in issue order.
  - The other requester's rd_valid = 0 that cycle; mX_rd_data holds its value when rd_valid = 0.
- Writes produce no response; write completion is implied by acceptance.
- Back-to-back reads from alternating masters pipeline fully: one return per cycle, correctly tagged.
- Reset mid-operation: in-flight tags are discarded. No mX_rd_valid is asserted after reset for reads issued before it, even if the slave still returns data. Any request pending at reset is not accepted during the reset cycle.
- Requester inputs may change freely while ready = 0; only the values present on the accept cycle are used.
- A requester holding valid continuously with the other idle gets ready every cycle.

Test Plan:
- M0 write addr 0x100 data 0xDEADBEEF at cycle 5 -> m0_req_ready=1 at cycle 5; s_wr_en=1, s_addr=0x100, s_wr_data=0xDEADBEEF at cycle 6 only.
- RD_LATENCY=1, M0 read 0x200 at cycle 5, slave returns 0x1234 at cycle 7 -> m0_rd_valid=1, m0_rd_data=0x1234 at cycle 8; m1_rd_valid=0 throughout.
- Both valid continuously from reset release -> grants M0,M1,M0,M1...; each ready alternates; s_addr alternates accordingly.
- RD_LATENCY=3, reads M0 A, M1 B, M0 C on consecutive accept cycles, slave returning 0xA/0xB/0xC -> rd_valid pulses on 3 consecutive cycles routed M0/M1/M0 with 0xA/0xB/0xC.
- M1 valid every cycle, M0 asserts valid once at cycle 10 -> M0 accepted at cycle 10 or 11 at the latest; M1 resumes the next cycle.
- RD_LATENCY=3, M1 read accepted, reset asserted 2 cycles later for 1 cycle -> no m1_rd_valid ever; all outputs 0 after reset; next grant goes to M0 under contention.
